// File: rtl/spi_arb.sv
// spi_arb: round-robin sequencer that shares one SPI master among NUM_REQ requesters.
// Optional watchdog (TIMEOUT parameter, err port) is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16
`ifdef SPI_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] cmd_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  busy,
  output logic [NUM_REQ-1:0]    ss_sel,
  output logic                  spi_wrt,
  output logic [DW-1:0]         spi_data_out,
  input  logic                  spi_done
`ifdef SPI_ARB_TIMEOUT_EN
  , output logic                err
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_LOW  = 3'd2;
  localparam logic [2:0] WAIT_HIGH = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [9:0]    wd;
`endif

  // Search starts one past the last winner and wraps, giving strict rotation.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= unsigned'(NUM_REQ); i++) begin
      cand = IW'((32'(last) + i) % unsigned'(NUM_REQ));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= IW'(NUM_REQ - 1);
      winner       <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      ss_sel       <= '0;
      spi_wrt      <= 1'b0;
      spi_data_out <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd           <= '0;
      err          <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            winner       <= pick;
            ss_sel       <= NUM_REQ'(1) << pick;
            spi_data_out <= cmd_data[pick*DW +: DW];
            spi_wrt      <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
            wd           <= '0;
`endif
          end
        end
        ISSUE: begin
          spi_wrt <= 1'b0;
          state   <= WAIT_LOW;
        end
        // done is still high from the previous idle period; only a low level counts here
        WAIT_LOW: begin
          if (!spi_done) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (spi_done) begin
            ack   <= NUM_REQ'(1) << winner;
            state <= ACK;
          end
        end
        ACK: begin
          last   <= winner;
          ss_sel <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ss_sel  <= '0;
          spi_wrt <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase

`ifdef SPI_ARB_TIMEOUT_EN
      // Abort overrides any completion seen on the same edge the count reaches TIMEOUT.
      if (state == WAIT_LOW || state == WAIT_HIGH) begin
        if (wd == 10'(TIMEOUT - 1)) begin
          err    <= 1'b1;
          ack    <= '0;
          ss_sel <= '0;
          busy   <= 1'b0;
          last   <= winner;
          state  <= IDLE;
        end else begin
          wd <= wd + 10'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: randomized scenarios against a round-robin reference model and a behavioural SPI master.
// Define SPI_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=20.
module tb_spi_arb;
  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO     = 20;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*DW-1:0] cmd_data = '0;
  logic [NUM_REQ-1:0]    ack;
  logic                  busy;
  logic [NUM_REQ-1:0]    ss_sel;
  logic                  spi_wrt;
  logic [DW-1:0]         spi_data_out;
  logic                  spi_done = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
  logic                  err;
`endif

  int checks = 0;
  int passes = 0;
  int last_ref = NUM_REQ - 1;

  spi_arb #(
    .NUM_REQ(NUM_REQ),
    .DW(DW)
`ifdef SPI_ARB_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .cmd_data(cmd_data),
    .ack(ack),
    .busy(busy),
    .ss_sel(ss_sel),
    .spi_wrt(spi_wrt),
    .spi_data_out(spi_data_out),
    .spi_done(spi_done)
`ifdef SPI_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // SPI master model: done stays high m_hold cycles after wrt, low for m_len cycles, or never drops when hung.
  int          m_hold = 0;
  int          m_len  = 4;
  bit          m_hang = 1'b0;
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_xfers = 0;
  logic [DW-1:0] m_cap = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_done <= 1'b1;
      m_phase  <= 0;
      m_cnt    <= 0;
    end else begin
      case (m_phase)
        0: if (spi_wrt) begin
             m_cap   <= spi_data_out;
             m_xfers <= m_xfers + 1;
             if (m_hang) m_phase <= 3;
             else if (m_hold == 0) begin spi_done <= 1'b0; m_cnt <= m_len; m_phase <= 2; end
             else begin m_cnt <= m_hold; m_phase <= 1; end
           end
        1: if (m_cnt <= 1) begin spi_done <= 1'b0; m_cnt <= m_len; m_phase <= 2; end
           else m_cnt <= m_cnt - 1;
        2: if (m_cnt <= 1) begin spi_done <= 1'b1; m_phase <= 0; end
           else m_cnt <= m_cnt - 1;
        default: if (!m_hang) m_phase <= 0;
      endcase
    end
  end

  // Reference arbitration: first requester found walking upward from last+1, modulo NUM_REQ.
  function automatic int ref_pick(input logic [NUM_REQ-1:0] r, input int l);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(l + k) % NUM_REQ]) return (l + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [DW-1:0] cmd_of(input int idx);
    logic [NUM_REQ*DW-1:0] c;
    c = cmd_data;
    return c[idx*DW +: DW];
  endfunction

  // Observation record of one transaction, filled by observe_txn.
  bit                 o_granted;
  logic [NUM_REQ-1:0] o_ss;
  logic [DW-1:0]      o_data;
  logic [NUM_REQ-1:0] o_ack;
  int                 o_wrt_len;
  bit                 o_ss_stable;
  bit                 o_done_low;
  bit                 o_busy_ok;
  logic [NUM_REQ-1:0] o_ss_after;
  logic [NUM_REQ-1:0] o_ack_after;

  task automatic observe_txn(input logic [NUM_REQ-1:0] drop);
    int n;
    o_granted = 0; o_ss = '0; o_data = '0; o_ack = '0; o_wrt_len = 0;
    o_ss_stable = 1; o_done_low = 0; o_busy_ok = 1; o_ss_after = '1; o_ack_after = '1;
    n = 0;
    while (n < 60 && spi_wrt !== 1'b1) begin @(negedge clk); n++; end
    if (spi_wrt !== 1'b1) return;
    o_granted = 1; o_ss = ss_sel; o_data = spi_data_out; o_wrt_len = 1;
    if (busy !== 1'b1) o_busy_ok = 0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (spi_wrt === 1'b1) o_wrt_len++;
      if (ss_sel !== o_ss) o_ss_stable = 0;
      if (busy !== 1'b1) o_busy_ok = 0;
      if (spi_done === 1'b0) o_done_low = 1;
    end while (ack === '0 && n < 300);
    o_ack = ack;
    req = req & ~(drop & ack);
    @(negedge clk);
    o_ss_after = ss_sel;
    o_ack_after = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; m_hang = 0; m_hold = 0; m_len = 4;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_ref = NUM_REQ - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (ack !== '0) $display("FAIL reset_ack: got %b want 0", ack); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (ss_sel !== '0) $display("FAIL reset_ss: got %b want 0", ss_sel); else passes++;
    checks++; if (spi_wrt !== 1'b0) $display("FAIL reset_wrt: got %b want 0", spi_wrt); else passes++;
    checks++; if (spi_data_out !== '0) $display("FAIL reset_data: got %h want 0", spi_data_out); else passes++;
`ifdef SPI_ARB_TIMEOUT_EN
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
`endif
    rst_n = 1'b1;
    last_ref = NUM_REQ - 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int e;
    logic [NUM_REQ-1:0] eoh;
    cmd_data = {$urandom, $urandom};
    cmd_data[15:0] = 16'hA5C3;
    m_hold = 0; m_len = 4;
    req = 4'b0001;
    e = ref_pick(req, last_ref);
    eoh = NUM_REQ'(1) << e;
    observe_txn(4'b0001);
    checks++; if (o_granted !== 1'b1) $display("FAIL single_grant: got %b want 1", o_granted); else passes++;
    checks++; if (o_data !== 16'hA5C3) $display("FAIL single_data: got %h want a5c3", o_data); else passes++;
    checks++; if (o_ss !== eoh) $display("FAIL single_ss: got %b want %b", o_ss, eoh); else passes++;
    checks++; if (o_wrt_len !== 1) $display("FAIL single_wrt_len: got %0d want 1", o_wrt_len); else passes++;
    checks++; if (o_ss_stable !== 1'b1) $display("FAIL single_ss_hold: got %b want 1", o_ss_stable); else passes++;
    checks++; if (o_busy_ok !== 1'b1) $display("FAIL single_busy: got %b want 1", o_busy_ok); else passes++;
    checks++; if (o_ack !== eoh) $display("FAIL single_ack: got %b want %b", o_ack, eoh); else passes++;
    checks++; if (o_ack_after !== '0) $display("FAIL single_ack_width: got %b want 0", o_ack_after); else passes++;
    checks++; if (o_ss_after !== '0) $display("FAIL single_ss_release: got %b want 0", o_ss_after); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else passes++;
    checks++; if (m_cap !== 16'hA5C3) $display("FAIL single_master_cap: got %h want a5c3", m_cap); else passes++;
    last_ref = e;
  endtask

  task automatic test_round_robin();
    int e;
    logic [NUM_REQ-1:0] eoh;
    do_reset();
    cmd_data = {$urandom, $urandom};
    req = '1;
    for (int t = 0; t < 5; t++) begin
      e = ref_pick(req, last_ref);
      eoh = NUM_REQ'(1) << e;
      observe_txn('0);
      checks++; if (o_ss !== eoh) $display("FAIL rr_grant%0d: got %b want %b", t, o_ss, eoh); else passes++;
      checks++; if (o_data !== cmd_of(e)) $display("FAIL rr_data%0d: got %h want %h", t, o_data, cmd_of(e)); else passes++;
      checks++; if (o_ack !== eoh || o_ack_after !== '0) $display("FAIL rr_ack%0d: got %b/%b want %b/0", t, o_ack, o_ack_after, eoh); else passes++;
      checks++; if (o_ss_after !== '0) $display("FAIL rr_gap%0d: got %b want 0", t, o_ss_after); else passes++;
      last_ref = e;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_late_done();
    int e, r;
    logic [NUM_REQ-1:0] eoh;
    r = $urandom_range(0, NUM_REQ - 1);
    cmd_data = {$urandom, $urandom};
    m_hold = 3; m_len = 3;
    req = NUM_REQ'(1) << r;
    e = ref_pick(req, last_ref);
    eoh = NUM_REQ'(1) << e;
    observe_txn(req);
    checks++; if (o_done_low !== 1'b1) $display("FAIL late_done_no_early_ack: got %b want 1", o_done_low); else passes++;
    checks++; if (o_ack !== eoh) $display("FAIL late_done_ack: got %b want %b", o_ack, eoh); else passes++;
    checks++; if (o_data !== cmd_of(e)) $display("FAIL late_done_data: got %h want %h", o_data, cmd_of(e)); else passes++;
    last_ref = e;
    m_hold = 0;
  endtask

  task automatic test_reset_mid();
    int n, e;
    logic [NUM_REQ-1:0] eoh;
    m_len = 8;
    req = 4'b0001;
    n = 0;
    while (n < 40 && spi_wrt !== 1'b1) begin @(negedge clk); n++; end
    n = 0;
    while (n < 40 && spi_done !== 1'b0) begin @(negedge clk); n++; end
    checks++; if (spi_done !== 1'b0) $display("FAIL rst_mid_reach: got done=%b want 0", spi_done); else passes++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ss_sel !== '0) $display("FAIL rst_mid_ss: got %b want 0", ss_sel); else passes++;
    checks++; if (busy !== 1'b0 || spi_wrt !== 1'b0) $display("FAIL rst_mid_busy_wrt: got %b%b want 00", busy, spi_wrt); else passes++;
    checks++; if (ack !== '0) $display("FAIL rst_mid_ack: got %b want 0", ack); else passes++;
    @(negedge clk);
    req = 4'b0101; m_len = 4;
    cmd_data = {$urandom, $urandom};
    last_ref = NUM_REQ - 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      e = ref_pick(req, last_ref);
      eoh = NUM_REQ'(1) << e;
      observe_txn('1);
      checks++; if (o_ss !== eoh) $display("FAIL rst_mid_grant%0d: got %b want %b", t, o_ss, eoh); else passes++;
      checks++; if (o_ack !== eoh) $display("FAIL rst_mid_ack%0d: got %b want %b", t, o_ack, eoh); else passes++;
      last_ref = e;
    end
  endtask

  task automatic test_drop_req();
    int xf;
    bit extra;
    cmd_data = {$urandom, $urandom};
    cmd_data[47:32] = 16'h1234;
    m_hold = 2; m_len = 3;
    req = 4'b0100;
    fork
      observe_txn(4'b0100);
      begin
        int n;
        n = 0;
        while (n < 60 && spi_wrt !== 1'b1) begin @(negedge clk); n++; end
        @(negedge clk);
        req[2] = 1'b0;
        cmd_data[47:32] = 16'h0000;
      end
    join
    checks++; if (o_data !== 16'h1234) $display("FAIL drop_data: got %h want 1234", o_data); else passes++;
    checks++; if (m_cap !== 16'h1234) $display("FAIL drop_master_cap: got %h want 1234", m_cap); else passes++;
    checks++; if (o_ack !== 4'b0100) $display("FAIL drop_ack: got %b want 0100", o_ack); else passes++;
    xf = m_xfers; extra = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (spi_wrt !== 1'b0) extra = 1; end
    checks++; if (extra !== 1'b0 || m_xfers !== xf) $display("FAIL drop_no_regrant: got wrt=%b xfers=%0d want 0/%0d", extra, m_xfers, xf); else passes++;
    last_ref = 2;
    m_hold = 0;
  endtask

  task automatic test_random();
    int e;
    logic [NUM_REQ-1:0] eoh;
    logic [DW-1:0] ed;
    for (int t = 0; t < 24; t++) begin
      m_hold = $urandom_range(0, 3);
      m_len = $urandom_range(1, 6);
      cmd_data = {$urandom, $urandom};
      req = req | NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      if (req == '0) req = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
      e = ref_pick(req, last_ref);
      eoh = NUM_REQ'(1) << e;
      ed = cmd_of(e);
      observe_txn($urandom_range(0, 1) != 0 ? '1 : '0);
      checks++; if (o_ss !== eoh || o_data !== ed) $display("FAIL rand_grant%0d: got %b/%h want %b/%h", t, o_ss, o_data, eoh, ed); else passes++;
      checks++; if (o_ack !== eoh || o_ack_after !== '0 || o_ss_after !== '0) $display("FAIL rand_ack%0d: got %b/%b/%b want %b/0/0", t, o_ack, o_ack_after, o_ss_after, eoh); else passes++;
      last_ref = e;
    end
    req = '0;
    m_hold = 0;
    @(negedge clk);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, k, e;
    bit saw_ack;
    logic [NUM_REQ-1:0] eoh;
    do_reset();
    cmd_data = {$urandom, $urandom};
    m_hang = 1;
    req = 4'b0011;
    e = ref_pick(req, last_ref);
    n = 0;
    while (n < 40 && spi_wrt !== 1'b1) begin @(negedge clk); n++; end
    k = 0; saw_ack = 0;
    while (k < 80 && err !== 1'b1) begin
      @(negedge clk); k++;
      if (ack !== '0) saw_ack = 1;
    end
    checks++; if (k !== TMO + 1) $display("FAIL tmo_latency: got %0d want %0d", k, TMO + 1); else passes++;
    checks++; if (saw_ack !== 1'b0) $display("FAIL tmo_no_ack: got %b want 0", saw_ack); else passes++;
    checks++; if (ss_sel !== '0 || busy !== 1'b0) $display("FAIL tmo_release: got %b/%b want 0/0", ss_sel, busy); else passes++;
    last_ref = e;
    m_hang = 0;
    req = '0;
    @(negedge clk);
    checks++; if (err !== 1'b0) $display("FAIL tmo_err_width: got %b want 0", err); else passes++;
    req = 4'b0011;
    e = ref_pick(req, last_ref);
    eoh = NUM_REQ'(1) << e;
    observe_txn('1);
    checks++; if (o_ss !== eoh || o_ack !== eoh) $display("FAIL tmo_next_grant: got %b/%b want %b", o_ss, o_ack, eoh); else passes++;
    last_ref = e;
    req = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_done();
    test_reset_mid();
    test_drop_req();
    test_random();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Round-robin arbiter and sequencer that shares the single 16-bit SPI master among NUM_REQ requesters, for example the per-channel gain/offset DACs and the trigger-level DAC.
- Latches the winning requester's 16-bit command and pulses the master's write strobe.
- Tracks the master's done signal through a full transaction, then returns a one-cycle ack to the requester.
- Drives a one-hot slave-select steering vector so board logic can route the master's SS_n to the addressed device.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 16, SPI command width; must match the SPI master data width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester transaction request; level, held until ack.
- cmd_data  input  NUM_REQ*DW  packed commands; requester i occupies bits [i*DW +: DW].
- ack  output  NUM_REQ  one-hot, one-cycle pulse when requester i's transfer completes.
- busy  output  1  high whenever state is not IDLE.
- ss_sel  output  NUM_REQ  one-hot slave steering, held for the whole transaction.
- spi_wrt  output  1  write strobe to the SPI master, one cycle.
- spi_data_out  output  DW  command to the SPI master, registered.
- spi_done  input  1  SPI master done; high when idle, low during a transfer.
- err  output  1  timeout pulse; exists only with SPI_ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE.
  - ack=0, busy=0, ss_sel=0, spi_wrt=0, spi_data_out=0, err=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has highest priority after reset.
- State machine, all outputs registered: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, ACK.
- IDLE:
  - If req is nonzero, select the first set bit searching from last+1 upward with wrap-around (modulo NUM_REQ).
  - On that clock edge: latch winner index, set ss_sel to the one-hot winner, load spi_data_out from cmd_data slice, set spi_wrt=1, go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE:
  - Lasts exactly one cycle, with spi_wrt high during it.
  - Next edge: spi_wrt=0, go to WAIT_LOW.
- WAIT_LOW:
  - Wait for spi_done==0. The master drops done the cycle after wrt; the arbiter must not treat the still-high done seen here as completion.
  - When spi_done==0, go to WAIT_HIGH.
- WAIT_HIGH:
  - Wait for spi_done==1, then go to ACK and assert ack[winner].
- ACK:
  - ack[winner] high for exactly one cycle; ss_sel held through this cycle.
  - last=winner.
  - Next edge: ss_sel=0, ack=0, go to IDLE.
- Throughput: the earliest next grant is the cycle after ACK, so ss_sel is low for at least one idle cycle between transactions.
- spi_data_out is held stable from ISSUE until the next grant. Requester cmd_data may change after the grant edge without effect.
- Requests are sampled only in IDLE.
  - req dropped before grant: no transaction.
  - req dropped mid-transaction: transaction completes and ack still pulses.
- Requester obligation: deassert req the cycle after ack. A req still high then is treated as a new request, at lowest priority because of the RR pointer.
- Simultaneous requests: grants rotate strictly; no requester is granted twice while another continuously requests.
- Without the optional feature, WAIT_LOW and WAIT_HIGH wait indefinitely.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 1023) and a 10-bit watchdog cleared on entry to ISSUE, counting in WAIT_LOW and WAIT_HIGH.
  - When the count reaches TIMEOUT: pulse err for one cycle, give no ack, set ss_sel=0, update last=winner, return to IDLE.
- When undefined: no err port and no counter; waits are unbounded.

Test Plan:
- Single request: req=4'b0001, cmd_data[15:0]=16'hA5C3 -> spi_wrt pulses one cycle, spi_data_out=16'hA5C3, ss_sel=4'b0001 until ack[0]; exactly one ack pulse after spi_done rises.
- All four requesting continuously after reset -> grant order 0,1,2,3,0; each ack one cycle wide; ss_sel low at least one cycle between grants.
- Late done drop: SPI model holds done high for 3 cycles after wrt -> arbiter stays in WAIT_LOW with no early ack; ack only after done goes low then high.
- Reset mid-transfer: assert rst_n=0 during WAIT_HIGH -> ss_sel, spi_wrt, busy, ack all 0 immediately; after release, requester 0 wins over 2 when req=4'b0101.
- req[2] dropped in WAIT_LOW with cmd_data[47:32] changed to 16'h0000 -> transfer still carries the original 16'h1234 and ack[2] still pulses.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=20, model never drops done -> err pulses 20 cycles after WAIT_LOW entry, no ack, next grant goes to the next requester in RR order.
